// File: rtl/moore_det_sched_if.sv
// Bundle of request, data, grant, detector and result signals between
// moore_det_sched, the channel sources and the shared Moore detector.
// master: scheduler side. slave: channel sources / detector / consumer side.
interface moore_det_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] bit_in;
    logic [N_REQ-1:0] grant;
    logic             bit_ack;
    logic             det_in;
    logic             det_reset;
    logic             det_out;
    logic             frame_done;
    logic [2:0]       frame_id;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;

    modport master (
        input  req, bit_in, det_out,
        output grant, bit_ack, det_in, det_reset, frame_done, frame_id,
               match_cnt, busy
    );

    modport slave (
        output req, bit_in, det_out,
        input  grant, bit_ack, det_in, det_reset, frame_done, frame_id,
               match_cnt, busy
    );
endinterface

// File: rtl/moore_det_sched.sv
// Round-robin scheduler time-sharing one Moore sequence detector among
// N_REQ serial channels. Each granted frame resets the detector, streams
// FRAME_LEN bits from the winner, drains the one-cycle Moore lag and reports
// the number of det_out-high cycles together with the winning channel id.
// Optional build macro MOORE_DET_SCHED_EARLY_STOP_EN: the first det_out seen
// while streaming ends the frame immediately (DRAIN skipped, match_cnt=1).
module moore_det_sched #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input logic               clk,
    input logic               reset,
    moore_det_sched_if.master bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win;
    logic [7:0]       bit_cnt;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] grant_r;
    logic             bit_ack_r;
    logic             load_r;
    logic             frame_done_r;
    logic [2:0]       frame_id_r;
    logic [CNT_W-1:0] match_cnt_r;
    logic             busy_r;

    // First set request at or after the pointer, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                  input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] k;
        logic             found;
        int               idx;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(p) + i) % N_REQ;
            k   = IDX_W'(idx);
            if (!found && r[k]) begin
                sel   = k;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

    // Frame sequencing FSM; every output except det_in/det_reset is a register here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            win          <= '0;
            bit_cnt      <= '0;
            cnt          <= '0;
            grant_r      <= '0;
            bit_ack_r    <= 1'b0;
            load_r       <= 1'b0;
            frame_done_r <= 1'b0;
            frame_id_r   <= '0;
            match_cnt_r  <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        win     <= rr_pick(bus.req, rr_ptr);
                        grant_r <= onehot(rr_pick(bus.req, rr_ptr));
                        load_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    load_r    <= 1'b0;
                    cnt       <= '0;
                    bit_cnt   <= '0;
                    bit_ack_r <= 1'b1;
                    state     <= STREAM;
                end
                STREAM: begin
                    bit_cnt <= bit_cnt + 8'd1;
`ifdef MOORE_DET_SCHED_EARLY_STOP_EN
                    if (bus.det_out) begin
                        // First match closes the frame; counter was still zero.
                        cnt          <= cnt + CNT_W'(1);
                        match_cnt_r  <= cnt + CNT_W'(1);
                        frame_id_r   <= 3'(win);
                        frame_done_r <= 1'b1;
                        grant_r      <= '0;
                        bit_ack_r    <= 1'b0;
                        state        <= DONE;
                    end else if (bit_cnt == 8'(FRAME_LEN - 1)) begin
                        bit_ack_r <= 1'b0;
                        state     <= DRAIN;
                    end
`else
                    if (bus.det_out) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (bit_cnt == 8'(FRAME_LEN - 1)) begin
                        bit_ack_r <= 1'b0;
                        state     <= DRAIN;
                    end
`endif
                end
                DRAIN: begin
                    // det_out now reflects the final streamed bit.
                    match_cnt_r  <= cnt + CNT_W'(bus.det_out);
                    cnt          <= cnt + CNT_W'(bus.det_out);
                    frame_id_r   <= 3'(win);
                    frame_done_r <= 1'b1;
                    grant_r      <= '0;
                    state        <= DONE;
                end
                DONE: begin
                    frame_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    rr_ptr       <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // det_in is a pure mux of the latched winner so the detector sees the bit
    // in the same cycle it is acknowledged; det_reset also covers system reset.
    assign bus.det_in     = bit_ack_r & bus.bit_in[win];
    assign bus.det_reset  = reset | load_r;
    assign bus.grant      = grant_r;
    assign bus.bit_ack    = bit_ack_r;
    assign bus.frame_done = frame_done_r;
    assign bus.frame_id   = frame_id_r;
    assign bus.match_cnt  = match_cnt_r;
    assign bus.busy       = busy_r;

endmodule
